// File: rtl/bounce_gen.sv
// -----------------------------------------------------------------------------
// bounce_gen : mechanical-switch emulator.
//
// Turns a clean command level into a contact-bounce waveform on sw, then holds
// the commanded level for a settle period before declaring the event complete.
// The bounce count and the bounce widths come from a free-running LFSR, so
// waveforms look random but repeat exactly after every reset.
//
// Parameters
//   TICK_BITS    : prescaler width; one bounce time unit every 2^TICK_BITS clks
//   SETTLE_TICKS : ticks sw holds the target before "settled" (1..255)
//   LFSR_SEED    : LFSR reset value (0 is replaced by 16'h0001)
//
// Ports
//   clk        : system clock, all state on rising edge
//   reset      : asynchronous, active-low reset
//   cmd        : clean requested switch level (synchronous to clk)
//   en_bounce  : 1 = emulate bounce, 0 = sw follows cmd directly
//   sw         : emulated raw switch signal (registered)
//   busy       : high while an event is bouncing or settling
//   settled    : one-cycle pulse when an event completes
//   toggle_cnt : number of sw edges in the last completed event
// -----------------------------------------------------------------------------
module bounce_gen #(
   parameter int          TICK_BITS    = 12,
   parameter int          SETTLE_TICKS = 8,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd,
   input  logic       en_bounce,
   output logic       sw,
   output logic       busy,
   output logic       settled,
   output logic [3:0] toggle_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_BOUNCE, S_SETTLE} state_t;

   // An all-zero seed would lock the LFSR up, so it is substituted.
   localparam logic [15:0]          SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [7:0]           SETTLE_LD = 8'(SETTLE_TICKS);
   localparam logic [TICK_BITS-1:0] PRE_ONE   = 1;

   state_t               state_q, state_d;
   logic [TICK_BITS-1:0] pre_q, pre_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic                 sw_q, sw_d;
   logic                 level_q, level_d;
   logic                 target_q, target_d;
   logic [2:0]           tog_left_q, tog_left_d;
   logic [3:0]           hold_q, hold_d;
   logic [7:0]           settle_q, settle_d;
   logic [3:0]           edge_q, edge_d;
   logic                 settled_q, settled_d;
   logic [3:0]           tcnt_q, tcnt_d;

   logic                 tick;
   logic [3:0]           hold_reload;
   logic [2:0]           tog_init;

   assign tick        = (pre_q == '0);
   // Hold lengths 1..8 ticks; a zero toggle field is bumped to 1 so every
   // bounced event has at least one bounce.
   assign hold_reload = {1'b0, lfsr_q[6:4]} + 4'd1;
   assign tog_init    = (lfsr_q[2:0] == 3'd0) ? 3'd1 : lfsr_q[2:0];

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         pre_q      <= '0;
         lfsr_q     <= SEED_EFF;
         sw_q       <= 1'b0;
         level_q    <= 1'b0;
         target_q   <= 1'b0;
         tog_left_q <= 3'd0;
         hold_q     <= 4'd0;
         settle_q   <= 8'd0;
         edge_q     <= 4'd0;
         settled_q  <= 1'b0;
         tcnt_q     <= 4'd0;
      end else begin
         state_q    <= state_d;
         pre_q      <= pre_d;
         lfsr_q     <= lfsr_d;
         sw_q       <= sw_d;
         level_q    <= level_d;
         target_q   <= target_d;
         tog_left_q <= tog_left_d;
         hold_q     <= hold_d;
         settle_q   <= settle_d;
         edge_q     <= edge_d;
         settled_q  <= settled_d;
         tcnt_q     <= tcnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      pre_d      = pre_q + PRE_ONE;
      // Fibonacci LFSR, taps 16,14,13,11; advances every cycle.
      lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      sw_d       = sw_q;
      level_d    = level_q;
      target_d   = target_q;
      tog_left_d = tog_left_q;
      hold_d     = hold_q;
      settle_d   = settle_q;
      edge_d     = edge_q;
      settled_d  = 1'b0;
      tcnt_d     = tcnt_q;

      case (state_q)
         S_IDLE: begin
            if (cmd != level_q) begin
               sw_d = cmd;
               if (!en_bounce) begin
                  level_d   = cmd;
                  settled_d = 1'b1;
                  tcnt_d    = 4'd1;
               end else begin
                  target_d   = cmd;
                  tog_left_d = tog_init;
                  hold_d     = hold_reload;
                  edge_d     = 4'd1;
                  state_d    = S_BOUNCE;
               end
            end
         end
         S_BOUNCE: begin
            if (tick) begin
               if (hold_q == 4'd1) begin
                  if (tog_left_q != 3'd0) begin
                     sw_d       = ~sw_q;
                     edge_d     = edge_q + 4'd1;
                     tog_left_d = tog_left_q - 3'd1;
                     hold_d     = hold_reload;
                  end else begin
                     // An odd number of inversions leaves sw on the wrong
                     // level; the closing edge restores the target.
                     if (sw_q != target_q) begin
                        sw_d   = target_q;
                        edge_d = edge_q + 4'd1;
                     end
                     settle_d = SETTLE_LD;
                     state_d  = S_SETTLE;
                  end
               end else begin
                  hold_d = hold_q - 4'd1;
               end
            end
         end
         S_SETTLE: begin
            if (tick) begin
               if (settle_q == 8'd1) begin
                  settled_d = 1'b1;
                  tcnt_d    = edge_q;
                  level_d   = target_q;
                  state_d   = S_IDLE;
               end else begin
                  settle_d = settle_q - 8'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      sw         = sw_q;
      busy       = (state_q != S_IDLE);
      settled    = settled_q;
      toggle_cnt = tcnt_q;
   end

endmodule
